noc_vc_fifo: RTL and testbench

- Parametrised successor to the single-channel router input FIFO.
- Holds NUM_VC independent virtual-channel queues, each DEPTH entries of NUM_BITS bits, in one router input port.
- Adds per-VC credit return, almost-full flags, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Feeds the router's VC allocator and switch.

---
 rtl/noc_vc_fifo.sv | 146 ++++++++++++++
 tb/tb_noc_vc_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_fifo.sv
// Multi-VC router input FIFO: NUM_VC independent queues with credit return and error flags.
// Latency: FWFT=0 read data one cycle after an accepted pop; FWFT=1 head flit visible combinationally.
// Backpressure: writes to a full VC and reads of an empty VC are rejected (sticky error), upstream paced by credit_out.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_en, wr_vc, fifo_in       write request, target VC, flit
//   rd_en, rd_vc                pop request, source VC
//   fifo_out, out_valid         read flit and its valid flag
//   empty, full, almost_full    per-VC status (bit v = VC v)
//   credit_out                  per-VC one-cycle pulse per popped flit
//   fifo_counter                per-VC occupancy, VC v at [v*(CW+1) +: CW+1]
//   overflow_err, underflow_err sticky rejected-write / rejected-read flags
module noc_vc_fifo #(
    parameter int NUM_BITS  = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_VC    = 2,
    parameter int FWFT      = 0,
    parameter int AFULL_LVL = DEPTH - 1,
    localparam int CW  = $clog2(DEPTH),
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [VCW-1:0]             wr_vc,
    input  logic [NUM_BITS-1:0]        fifo_in,
    input  logic                       rd_en,
    input  logic [VCW-1:0]             rd_vc,
    output logic [NUM_BITS-1:0]        fifo_out,
    output logic                       out_valid,
    output logic [NUM_VC-1:0]          empty,
    output logic [NUM_VC-1:0]          full,
    output logic [NUM_VC-1:0]          almost_full,
    output logic [NUM_VC-1:0]          credit_out,
    output logic [NUM_VC*(CW+1)-1:0]   fifo_counter,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam logic [VCW:0] VC_LIM  = (VCW+1)'(NUM_VC);
    localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW:0]  AFULL_C = (CW+1)'(AFULL_LVL);

    logic [NUM_BITS-1:0] mem    [NUM_VC][DEPTH];
    logic [CW-1:0]       wr_ptr [NUM_VC];
    logic [CW-1:0]       rd_ptr [NUM_VC];
    logic [CW:0]         cnt    [NUM_VC];

    logic                wr_vc_ok, rd_vc_ok;
    logic [VCW-1:0]      wr_idx, rd_idx;
    logic                wr_acc, rd_acc;
    logic [NUM_VC-1:0]   wr_sel, rd_sel;
    logic [NUM_BITS-1:0] head;

    // Out-of-range VC numbers are folded to 0 for indexing so array reads stay
    // in bounds; the *_ok terms keep such requests from being accepted.
    assign wr_vc_ok = ({1'b0, wr_vc} < VC_LIM);
    assign rd_vc_ok = ({1'b0, rd_vc} < VC_LIM);
    assign wr_idx   = wr_vc_ok ? wr_vc : '0;
    assign rd_idx   = rd_vc_ok ? rd_vc : '0;

    always_comb begin
        empty        = '0;
        full         = '0;
        almost_full  = '0;
        fifo_counter = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v]                      = (cnt[v] == '0);
            full[v]                       = (cnt[v] == DEPTH_C);
            almost_full[v]                = (cnt[v] >= AFULL_C);
            fifo_counter[v*(CW+1) +: CW+1] = cnt[v];
        end
    end

    // No bypass: acceptance looks only at the occupancy before this edge.
    assign wr_acc = wr_en && wr_vc_ok && !full[wr_idx];
    assign rd_acc = rd_en && rd_vc_ok && !empty[rd_idx];

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = wr_acc && (wr_idx == VCW'(v));
            rd_sel[v] = rd_acc && (rd_idx == VCW'(v));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                cnt[v]    <= '0;
            end
            credit_out    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_sel[v])
                    wr_ptr[v] <= wr_ptr[v] + CW'(1);
                if (rd_sel[v])
                    rd_ptr[v] <= rd_ptr[v] + CW'(1);
                if (wr_sel[v] && !rd_sel[v])
                    cnt[v] <= cnt[v] + (CW+1)'(1);
                else if (!wr_sel[v] && rd_sel[v])
                    cnt[v] <= cnt[v] - (CW+1)'(1);
            end
            credit_out <= rd_sel;
            if (wr_en && !wr_acc)
                overflow_err <= 1'b1;
            if (rd_en && !rd_acc)
                underflow_err <= 1'b1;
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_idx][wr_ptr[wr_idx]] <= fifo_in;
    end

    assign head = mem[rd_idx][rd_ptr[rd_idx]];

    generate
        if (FWFT != 0) begin : g_fwft
            // Data is forced to zero while nothing valid is displayed so the
            // output never exposes stale or uninitialised storage.
            assign out_valid = rd_vc_ok && !empty[rd_idx];
            assign fifo_out  = out_valid ? head : '0;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_out  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= rd_acc;
                    if (rd_acc)
                        fifo_out <= head;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Directed bench for noc_vc_fifo: a registered-read instance driven from a
// vector table plus hand sequences, and an FWFT instance for the fall-through
// and asynchronous-reset cases.
module tb_noc_vc_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read DUT
    logic       rst_n, wr_en, wr_vc, rd_en, rd_vc;
    logic [7:0] fifo_in, fifo_out;
    logic       out_valid, overflow_err, underflow_err;
    logic [1:0] empty, full, almost_full, credit_out;
    logic [7:0] fifo_counter;

    // FWFT DUT
    logic       f_rst_n, f_wr_en, f_wr_vc, f_rd_en, f_rd_vc;
    logic [7:0] f_fifo_in, f_fifo_out;
    logic       f_out_valid, f_overflow_err, f_underflow_err;
    logic [1:0] f_empty, f_full, f_almost_full, f_credit_out;
    logic [7:0] f_fifo_counter;

    noc_vc_fifo #(.NUM_BITS(8), .DEPTH(8), .NUM_VC(2), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_vc(wr_vc), .fifo_in(fifo_in),
        .rd_en(rd_en), .rd_vc(rd_vc), .fifo_out(fifo_out), .out_valid(out_valid),
        .empty(empty), .full(full), .almost_full(almost_full), .credit_out(credit_out),
        .fifo_counter(fifo_counter), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    noc_vc_fifo #(.NUM_BITS(8), .DEPTH(8), .NUM_VC(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(f_rst_n), .wr_en(f_wr_en), .wr_vc(f_wr_vc), .fifo_in(f_fifo_in),
        .rd_en(f_rd_en), .rd_vc(f_rd_vc), .fifo_out(f_fifo_out), .out_valid(f_out_valid),
        .empty(f_empty), .full(f_full), .almost_full(f_almost_full), .credit_out(f_credit_out),
        .fifo_counter(f_fifo_counter), .overflow_err(f_overflow_err),
        .underflow_err(f_underflow_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic       wvc;
        logic [7:0] din;
        logic       re;
        logic       rvc;
        logic [1:0] e_empty;
        logic [1:0] e_full;
        logic [1:0] e_afull;
        logic [3:0] e_c0;
        logic [3:0] e_c1;
        logic       e_ov;
        logic [7:0] e_dout;
        logic [1:0] e_cred;
        logic       e_oerr;
        logic       e_uerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int we, int wvc, int din, int re, int rvc, int em, int fu,
                                int af, int c0, int c1, int ov, int dout, int cr,
                                int oe, int ue);
        vec_t v;
        v.we = 1'(we);      v.wvc = 1'(wvc);   v.din = 8'(din);
        v.re = 1'(re);      v.rvc = 1'(rvc);
        v.e_empty = 2'(em); v.e_full = 2'(fu); v.e_afull = 2'(af);
        v.e_c0 = 4'(c0);    v.e_c1 = 4'(c1);   v.e_ov = 1'(ov);
        v.e_dout = 8'(dout); v.e_cred = 2'(cr);
        v.e_oerr = 1'(oe);  v.e_uerr = 1'(ue);
        return v;
    endfunction

    // Drive one cycle of stimulus on the registered DUT; returns #1 after the edge.
    task automatic apply(input logic we, input logic wvc, input logic [7:0] din,
                         input logic re, input logic rvc);
        wr_en = we; wr_vc = wvc; fifo_in = din; rd_en = re; rd_vc = rvc;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic fapply(input logic we, input logic wvc, input logic [7:0] din,
                          input logic re, input logic rvc);
        f_wr_en = we; f_wr_vc = wvc; f_fifo_in = din; f_rd_en = re; f_rd_vc = rvc;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        string tag;
        logic [7:0] exp_d;

        rst_n = 1'b0; wr_en = 1'b0; wr_vc = 1'b0; fifo_in = '0; rd_en = 1'b0; rd_vc = 1'b0;
        f_rst_n = 1'b0; f_wr_en = 1'b0; f_wr_vc = 1'b0; f_fifo_in = '0;
        f_rd_en = 1'b0; f_rd_vc = 1'b0;

        // Fill VC0 with 0x10..0x17, then one rejected write.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 'h10 + i, 0, 0, 'b10, (i == 7) ? 'b01 : 0,
                              (i >= 6) ? 'b01 : 0, i + 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h18, 0, 0, 'b10, 'b01, 'b01, 8, 0, 0, 0, 0, 1, 0));
        // Drain VC0 in order, then one rejected read and an idle cycle.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 0, 1, 0, (i == 7) ? 'b11 : 'b10, 0, (i == 0) ? 'b01 : 0,
                              7 - i, 0, 1, 'h10 + i, 'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'b11, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'b11, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        // Interleave: read VC1 while writing VC0.
        vecs.push_back(mk(1, 1, 'hB0, 0, 0, 'b01, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 'hB1, 0, 0, 'b01, 0, 0, 0, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 'hA0, 1, 1, 'b00, 0, 0, 1, 1, 1, 'hB0, 'b10, 1, 1));
        vecs.push_back(mk(1, 0, 'hA1, 1, 1, 'b10, 0, 0, 2, 0, 1, 'hB1, 'b10, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'b10, 0, 0, 1, 0, 1, 'hA0, 'b01, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'b11, 0, 0, 0, 0, 1, 'hA1, 'b01, 1, 1));

        // Reset values (asynchronous, checked before any clock edge matters).
        #3;
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_afull", almost_full, 2'b00);
        chk("rst_counter", fifo_counter, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fifo_out", fifo_out, 8'h00);
        chk("rst_credit", credit_out, 2'b00);
        chk("rst_errs", {overflow_err, underflow_err}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v.we, v.wvc, v.din, v.re, v.rvc);
            tag = $sformatf("vec%0d", i);
            chk({tag, "_empty"}, empty, v.e_empty);
            chk({tag, "_full"}, full, v.e_full);
            chk({tag, "_afull"}, almost_full, v.e_afull);
            chk({tag, "_cnt0"}, fifo_counter[3:0], v.e_c0);
            chk({tag, "_cnt1"}, fifo_counter[7:4], v.e_c1);
            chk({tag, "_out_valid"}, out_valid, v.e_ov);
            if (v.e_ov)
                chk({tag, "_fifo_out"}, fifo_out, v.e_dout);
            chk({tag, "_credit"}, credit_out, v.e_cred);
            chk({tag, "_ovf"}, overflow_err, v.e_oerr);
            chk({tag, "_unf"}, underflow_err, v.e_uerr);
        end

        // Reset clears queues and sticky flags; refill VC0 to full.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        chk("rst2_errs", {overflow_err, underflow_err}, 2'b00);
        chk("rst2_counter", fifo_counter, 8'h00);
        for (int i = 0; i < 8; i++)
            apply(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("fill_cnt0", fifo_counter[3:0], 4'd8);
        chk("fill_full", full, 2'b01);

        // Full VC0, write+read on VC0: read wins, write rejected.
        apply(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        chk("fullrw_cnt0", fifo_counter[3:0], 4'd7);
        chk("fullrw_ovf", overflow_err, 1'b1);
        chk("fullrw_out_valid", out_valid, 1'b1);
        chk("fullrw_fifo_out", fifo_out, 8'h20);
        chk("fullrw_credit", credit_out, 2'b01);
        chk("fullrw_unf", underflow_err, 1'b0);

        // Empty VC1, write+read on VC1: write wins, read rejected.
        apply(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        chk("emptyrw_cnt1", fifo_counter[7:4], 4'd1);
        chk("emptyrw_unf", underflow_err, 1'b1);
        chk("emptyrw_out_valid", out_valid, 1'b0);
        chk("emptyrw_credit", credit_out, 2'b00);

        // Occupancy 3 on VC1, then 20 write/read pairs across pointer wrap.
        apply(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
        chk("wrap_pre_cnt1", fifo_counter[7:4], 4'd3);
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, 1'b1, 8'(8'hC2 + k), 1'b1, 1'b1);
            exp_d = (k == 0) ? 8'h77 : 8'(8'hC0 + k - 1);
            chk($sformatf("wrap%0d_fifo_out", k), fifo_out, exp_d);
            chk($sformatf("wrap%0d_cnt1", k), fifo_counter[7:4], 4'd3);
            chk($sformatf("wrap%0d_credit", k), credit_out, 2'b10);
        end
        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_out_valid", out_valid, 1'b0);
        chk("hold_fifo_out", fifo_out, 8'hD2);
        chk("hold_cnt0", fifo_counter[3:0], 4'd7);

        // FWFT instance.
        #2;
        chk("f_rst_out_valid", f_out_valid, 1'b0);
        chk("f_rst_fifo_out", f_fifo_out, 8'h00);
        f_rst_n = 1'b1;
        fapply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("f_unf", f_underflow_err, 1'b1);
        fapply(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        chk("f_show_valid", f_out_valid, 1'b1);
        chk("f_show_data", f_fifo_out, 8'h55);
        fapply(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
        chk("f_head_kept", f_fifo_out, 8'h55);
        f_rd_vc = 1'b1; #1;
        chk("f_vc1_invalid", f_out_valid, 1'b0);
        fapply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("f_pop_next", f_fifo_out, 8'h66);
        chk("f_pop_valid", f_out_valid, 1'b1);
        chk("f_pop_credit", f_credit_out, 2'b01);
        chk("f_pop_cnt0", f_fifo_counter[3:0], 4'd1);
        // Mid-cycle asynchronous reset.
        #2; f_rst_n = 1'b0; #1;
        chk("f_arst_credit", f_credit_out, 2'b00);
        chk("f_arst_counter", f_fifo_counter, 8'h00);
        chk("f_arst_empty", f_empty, 2'b11);
        chk("f_arst_out_valid", f_out_valid, 1'b0);
        chk("f_arst_fifo_out", f_fifo_out, 8'h00);
        chk("f_arst_errs", {f_overflow_err, f_underflow_err}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
